// File: rtl/fifo_wr_source_if.sv
// fifo_wr_source_if: write-port bundle between a traffic source and the
// async FIFO write side (strobe, data, registered full and overflow flags).
interface fifo_wr_source_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  wr_overflow;

  modport master (
    output winc,
    output wdata,
    input  wfull,
    input  wr_overflow
  );

  modport slave (
    input  winc,
    input  wdata,
    output wfull,
    output wr_overflow
  );
endinterface

// File: rtl/fifo_wr_source.sv
// fifo_wr_source: write-domain traffic generator for the async FIFO.
// Issues num_words writes in bursts of BURST_LEN separated by GAP_CYCLES idle
// cycles, stalls on wfull, supports abort and captures FIFO overflow in err.
// Define FIFO_SRC_LFSR_EN to replace the incrementing data pattern with a
// Fibonacci LFSR (a zero seed is replaced by all-ones).
module fifo_wr_source #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int SOFT_RESET = 2
) (
  input  logic                  wclk,
  input  logic                  hw_rst,
  input  logic                  sw_wrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  num_words,
  input  logic [DATA_WIDTH-1:0] seed,
  fifo_wr_source_if.master      wr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_sent
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BCW-1:0] BURST_MAX = BCW'(BURST_LEN - 1);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef FIFO_SRC_LFSR_EN
  // Maximal-length feedback taps (bit i set = stage i+1 tapped).
  function automatic logic [DATA_WIDTH-1:0] tap_mask();
    logic [DATA_WIDTH-1:0] m;
    case (DATA_WIDTH)
      2:       m = DATA_WIDTH'(32'h0000_0003);
      3:       m = DATA_WIDTH'(32'h0000_0006);
      4:       m = DATA_WIDTH'(32'h0000_000C);
      5:       m = DATA_WIDTH'(32'h0000_0014);
      6:       m = DATA_WIDTH'(32'h0000_0030);
      7:       m = DATA_WIDTH'(32'h0000_0060);
      9:       m = DATA_WIDTH'(32'h0000_0110);
      10:      m = DATA_WIDTH'(32'h0000_0240);
      11:      m = DATA_WIDTH'(32'h0000_0500);
      12:      m = DATA_WIDTH'(32'h0000_0829);
      13:      m = DATA_WIDTH'(32'h0000_100D);
      14:      m = DATA_WIDTH'(32'h0000_2015);
      15:      m = DATA_WIDTH'(32'h0000_6000);
      16:      m = DATA_WIDTH'(32'h0000_D008);
      24:      m = DATA_WIDTH'(32'h00E1_0000);
      32:      m = DATA_WIDTH'(32'h8020_0003);
      default: m = DATA_WIDTH'(32'h0000_00B8);
    endcase
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] next_pattern(input logic [DATA_WIDTH-1:0] d);
    return {d[DATA_WIDTH-2:0], ^(d & tap_mask())};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_seed(input logic [DATA_WIDTH-1:0] s);
    return (s == '0) ? '1 : s;
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] next_pattern(input logic [DATA_WIDTH-1:0] d);
    return d + DATA_WIDTH'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_seed(input logic [DATA_WIDTH-1:0] s);
    return s;
  endfunction
`endif

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [BCW-1:0]        burst_q, burst_d;
  logic [GCW-1:0]        gap_q, gap_d;
  logic                  err_q, err_d;
  logic                  soft_rst;
  logic                  accept;
  logic                  burst_last;
  logic                  stop_req;

  assign soft_rst   = sw_wrst && (SOFT_RESET == 2 || SOFT_RESET == 3);
  assign accept     = (state_q == ST_BURST) && !wr.wfull && !abort && !soft_rst;
  assign burst_last = (burst_q == BURST_MAX);
  assign stop_req   = abort || wr.wr_overflow;

  assign wr.winc   = accept;
  assign wr.wdata  = data_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign words_sent = words_q;

  // Next-state and datapath: start capture, accept bookkeeping, burst/gap sequencing, abort/overflow exit.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    words_d = words_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    err_d   = err_q;
    if (soft_rst) begin
      state_d = ST_IDLE;
      data_d  = '0;
      len_d   = '0;
      words_d = '0;
      burst_d = '0;
      gap_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (wr.wr_overflow && state_q != ST_IDLE) begin
        err_d = 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_d   = 1'b0;
            words_d = '0;
            burst_d = '0;
            if (num_words == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_BURST;
              len_d   = num_words;
              data_d  = load_seed(seed);
            end
          end
        end
        ST_BURST: begin
          if (accept) begin
            data_d  = next_pattern(data_q);
            words_d = words_q + LEN_WIDTH'(1);
            burst_d = burst_last ? '0 : burst_q + BCW'(1);
            if (words_q + LEN_WIDTH'(1) == len_q) begin
              state_d = ST_DONE;
            end else if (burst_last && GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LOAD;
            end
          end
          if (stop_req) begin
            state_d = ST_DONE;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_d = ST_BURST;
          end else begin
            gap_d = gap_q - GCW'(1);
          end
          if (stop_req) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by hw_rst.
  always_ff @(posedge wclk or negedge hw_rst) begin
    if (!hw_rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      len_q   <= '0;
      words_q <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      words_q <= words_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/fifo_wr_source.md
Name: fifo_wr_source

Overview:
- Write-side producer for the async FIFO. Runs in the write clock domain.
- Generates winc/wdata bursts into the FIFO write port and obeys the FIFO's registered wfull flag, so the FIFO never raises wr_overflow.
- Used as the traffic source in FIFO subsystem benches and as the loader for built-in self-test.
- Supports programmable word count, fixed burst length with inter-burst gaps, abort, and overflow error capture.

Parameters:
- DATA_WIDTH, 8, width of wdata.
- LEN_WIDTH, 8, width of num_words and words_sent.
- BURST_LEN, 4, words per burst (>=1).
- GAP_CYCLES, 2, idle cycles between bursts; 0 means continuous streaming.
- SOFT_RESET, 2, sw_wrst acts as a synchronous reset only when the value is 2 or 3.

Ports:
- wclk  in  1  write clock.
- hw_rst  in  1  reset, asynchronous, active-low.
- sw_wrst  in  1  synchronous soft reset, qualified by SOFT_RESET.
- start  in  1  begin a transfer; sampled only in IDLE.
- abort  in  1  stop the transfer after the current cycle.
- num_words  in  LEN_WIDTH  words to send; captured on start.
- seed  in  DATA_WIDTH  first data word; captured on start.
- wfull  in  1  FIFO full flag (registered, wclk domain).
- wr_overflow  in  1  FIFO overflow flag.
- winc  out  1  FIFO write strobe.
- wdata  out  DATA_WIDTH  FIFO write data.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  overflow seen during the transfer; sticky until the next start.
- words_sent  out  LEN_WIDTH  count of accepted writes.

Behaviour:
- Reset (hw_rst low, or sw_wrst with SOFT_RESET 2/3): state IDLE. winc, done, err, busy are 0. wdata, words_sent and internal counters are 0.
- States: IDLE, BURST, GAP, DONE.
- IDLE:
  - start=1 with num_words=0 -> DONE (no writes).
  - start=1 with num_words>0 -> BURST. Capture num_words into len_r, load data_r=seed, clear words_sent, burst_cnt and err.
- Write acceptance: winc = (state==BURST) & ~wfull & ~abort, combinational. A word is accepted on a wclk edge where winc=1. wdata=data_r at all times.
- On each accept: data_r advances to the next pattern value, words_sent+1, burst_cnt+1.
- Data pattern: data_r+1, wrapping modulo 2^DATA_WIDTH.
- Backpressure: while wfull=1 in BURST, winc=0 and data_r is held. Transfer resumes on the first cycle wfull=0. No words are lost or duplicated.
- BURST exits, evaluated on an accept:
  - words_sent+1 == len_r -> DONE.
  - else burst_cnt+1 == BURST_LEN and GAP_CYCLES>0 -> GAP. Clear burst_cnt, load gap_cnt=GAP_CYCLES-1.
  - If GAP_CYCLES==0, burst_cnt wraps and the FSM stays in BURST.
- GAP: winc=0. gap_cnt decrements; at 0 -> BURST.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 only in IDLE.
- abort=1 in BURST or GAP: winc is forced 0 that cycle, next state DONE. words_sent keeps the partial count.
- wr_overflow=1 while busy: err<=1, next state DONE. The current cycle's write is still issued if otherwise legal.
- start while busy is ignored. start in the same cycle as the DONE pulse is ignored; a new start is accepted in IDLE only.
- Simultaneous abort and overflow: same path (DONE); err=1.
- sw_wrst mid-transfer (SOFT_RESET 2/3): immediate return to IDLE, no done pulse, outputs as at reset.
- Latency: start to first winc is 1 cycle, given wfull=0.
- Peak throughput: 1 word/cycle when GAP_CYCLES=0 and wfull=0.

Optional Feature:
- FIFO_SRC_LFSR_EN defined: the data pattern is a Fibonacci LFSR over DATA_WIDTH bits, taps per the maximal-length table, seeded from seed. A seed of 0 is replaced by all-ones.
- Undefined: incrementing pattern as described in Behaviour.
- All other behaviour is identical.

Test Plan:
- num_words=10, seed=8'h20, BURST_LEN=4, GAP_CYCLES=2, wfull=0 -> winc high on cycles 1-4, 7-10, 13-14 after start; wdata 8'h20..8'h29; words_sent=10; done pulse one cycle after the last write; err=0.
- Same transfer, wfull forced 1 for 3 cycles after the 2nd accept -> winc=0 and wdata held at 8'h22 during the stall; sequence continues 8'h22..8'h29 with no gaps or duplicates.
- num_words=0, start -> done pulse next cycle, winc never asserted, words_sent=0.
- num_words=50, abort at the 7th accept cycle -> that cycle winc=0, words_sent=6, DONE then IDLE, err=0.
- wr_overflow pulsed mid-transfer -> err=1 and DONE; err stays 1 in IDLE until the next start clears it.
- hw_rst asserted mid-burst -> all outputs 0 asynchronously. After release, start with seed=8'hFF, num_words=2 -> wdata 8'hFF then 8'h00 (wrap). With FIFO_SRC_LFSR_EN, seed=0 -> first wdata all-ones.
